sequence_detector: RTL and testbench

Serial bit-pattern detector: watches a 1-bit serial stream and flags every occurrence of the pattern 1011, overlaps included, with a registered one-cycle pulse. It is fed by the companion pattern source `sequence_generator`, and both are instantiated side by side in the detector test environment. The detector is a five-state Moore FSM clocked on `clk`.

---
 rtl/seq_det_pkg.sv | 27 ++
 rtl/sequence_generator.sv | 44 ++++
 rtl/sequence_detector.sv | 83 ++++++++
 tb/tb_sequence_detector.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the 1011 serial pattern detector and its companion
// pattern source:
//   state_e                 - detector FSM states (3-bit encoding)
//   SEQ_DET_PATTERN         - the detected pattern, 1011 (MSB is seen first)
//   SEQ_GEN_DEFAULT_PATTERN - default 16-bit stream of sequence_generator
//   state_is_match()        - Moore output decode of a state
// -----------------------------------------------------------------------------
package seq_det_pkg;

  typedef enum logic [2:0] {
    S0    = 3'd0,  // idle, no useful prefix
    S1    = 3'd1,  // seen "1"
    S10   = 3'd2,  // seen "10"
    S101  = 3'd3,  // seen "101"
    S1011 = 3'd4   // seen "1011" -> match
  } state_e;

  localparam logic [3:0]  SEQ_DET_PATTERN         = 4'b1011;
  localparam logic [15:0] SEQ_GEN_DEFAULT_PATTERN = 16'b1011_0110_1101_1000;

  function automatic logic state_is_match(input state_e s);
    return (s == S1011);
  endfunction

endpackage

// File: rtl/sequence_generator.sv
// -----------------------------------------------------------------------------
// sequence_generator
// Pattern source for the detector: shifts GEN_PATTERN out MSB first, one bit
// per rising clk, repeating every 16 cycles.
// Parameters:
//   GEN_PATTERN - 16-bit stream (default SEQ_GEN_DEFAULT_PATTERN)
// Ports:
//   clk   in  1  rising-edge clock
//   reset in  1  asynchronous active-low reset (index=0, seq=0)
//   seq   out 1  registered serial bit, GEN_PATTERN[15-index]
// -----------------------------------------------------------------------------
module sequence_generator
  import seq_det_pkg::*;
#(
  parameter logic [15:0] GEN_PATTERN = SEQ_GEN_DEFAULT_PATTERN
) (
  input  logic clk,
  input  logic reset,
  output logic seq
);

  logic [3:0] index_q, index_d;
  logic       seq_q, seq_d;

  // Next index (wraps 15 -> 0 naturally) and the bit loaded for this index.
  always_comb begin
    index_d = index_q + 4'd1;
    seq_d   = GEN_PATTERN[4'd15 - index_q];
  end

  // Index and output bit registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index_q <= 4'd0;
      seq_q   <= 1'b0;
    end else begin
      index_q <= index_d;
      seq_q   <= seq_d;
    end
  end

  assign seq = seq_q;

endmodule

// File: rtl/sequence_detector.sv
// -----------------------------------------------------------------------------
// sequence_detector
// Moore FSM flagging every occurrence (overlaps included) of the serial
// pattern 1011 with a one-cycle pulse on y.
// Optional build macro: SEQ_DET_COUNT_EN adds an 8-bit wrapping match counter.
// Ports:
//   clk         in  1  rising-edge clock
//   reset       in  1  asynchronous active-low reset (state S0, y=0, count=0)
//   x           in  1  serial data bit, sampled on each rising clk
//   y           out 1  match pulse, 1 while the state is S1011
//   match_count out 8  number of matches seen (SEQ_DET_COUNT_EN only)
// -----------------------------------------------------------------------------
module sequence_detector
  import seq_det_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
  output logic       y
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [7:0] match_count
`endif
);

  state_e state_q, state_d;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. In each partial-match state x is compared with the next
  // expected pattern bit; on a miss we fall back to the longest suffix of what
  // was seen that is still a prefix of 1011 (this is what makes overlaps work).
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = (x == SEQ_DET_PATTERN[3]) ? S1    : S0;
      S1:      state_d = (x == SEQ_DET_PATTERN[2]) ? S10   : S1;
      S10:     state_d = (x == SEQ_DET_PATTERN[1]) ? S101  : S0;
      S101:    state_d = (x == SEQ_DET_PATTERN[0]) ? S1011 : S10;
      // After a match the trailing "1" is reused as a new prefix.
      S1011:   state_d = x ? S1 : S10;
      // Unused encodings recover to idle.
      default: state_d = S0;
    endcase
  end

  // Moore output: decoded from the state register only, no path from x.
  always_comb begin
    y = state_is_match(state_q);
  end

`ifdef SEQ_DET_COUNT_EN
  logic [7:0] match_count_q, match_count_d;

  // Count on the edge that enters S1011 so the counter moves together with y.
  always_comb begin
    if (state_is_match(state_d)) begin
      match_count_d = match_count_q + 8'd1;
    end else begin
      match_count_d = match_count_q;
    end
  end

  // Match counter register (wraps 255 -> 0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_count_q <= 8'd0;
    end else begin
      match_count_q <= match_count_d;
    end
  end

  assign match_count = match_count_q;
`endif

endmodule

// File: tb/tb_sequence_detector.sv
// -----------------------------------------------------------------------------
// tb_sequence_detector
// Directed and random stimulus for sequence_detector, with sequence_generator
// as an alternate stream source. The reference keeps the last four sampled
// bits and flags a match when they read 1011.
// -----------------------------------------------------------------------------
module tb_sequence_detector;

  localparam logic [15:0] GEN_PAT = 16'b1011_0110_1101_1000;

  logic       clk;
  logic       reset;
  logic       x_tb;
  logic       use_gen;
  logic       x_mux;
  logic       y;
  logic       seq;
`ifdef SEQ_DET_COUNT_EN
  logic [7:0] match_count;
`endif

  int checks;
  int failures;

  // reference model state
  logic [3:0] hist;
  int         nsamp;
  logic [7:0] exp_cnt;
  int         gen_edges;

  assign x_mux = use_gen ? seq : x_tb;

  sequence_detector dut (
    .clk   (clk),
    .reset (reset),
    .x     (x_mux),
    .y     (y)
`ifdef SEQ_DET_COUNT_EN
    ,
    .match_count (match_count)
`endif
  );

  sequence_generator u_gen (
    .clk   (clk),
    .reset (reset),
    .seq   (seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    hist      = 4'd0;
    nsamp     = 0;
    exp_cnt   = 8'd0;
    gen_edges = 0;
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_y", {31'd0, y}, 32'd0);
`ifdef SEQ_DET_COUNT_EN
    check("async_rst_cnt", {24'd0, match_count}, 32'd0);
`endif
    check("async_rst_seq", {31'd0, seq}, 32'd0);
    model_clear();
    #1;
    reset = 1'b1;
  endtask

  // One clock: sample the bit the DUT will see, clock, update the model, compare.
  // dir >= 0 additionally compares y with a hand-written expected value.
  task automatic step(input logic b, input int dir, input string tag);
    logic s;
    logic e;
    x_tb = b;
    #1;
    s = x_mux;
    @(posedge clk);
    hist  = {hist[2:0], s};
    nsamp = nsamp + 1;
    gen_edges = gen_edges + 1;
    e = (nsamp >= 4) && (hist == 4'b1011);
    if (e) exp_cnt = exp_cnt + 8'd1;
    #1;
    check({tag, "_model"}, {31'd0, y}, {31'd0, e});
    if (dir >= 0) check({tag, "_dir"}, {31'd0, y}, dir[31:0]);
`ifdef SEQ_DET_COUNT_EN
    check({tag, "_cnt"}, {24'd0, match_count}, {24'd0, exp_cnt});
`endif
  endtask

  initial begin
    logic bits_single [5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int   ys_single   [5]  = '{0, 0, 0, 1, 0};
    logic bits_ovl    [7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int   ys_ovl      [7]  = '{0, 0, 0, 1, 0, 0, 1};
    logic bits_near   [9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int   pulses;
    int   last_pulse;
    int   bitidx;
    logic exp_seq;
    logic [15:0] pat;

    checks   = 0;
    failures = 0;
    use_gen  = 1'b0;
    x_tb     = 1'b0;
    reset    = 1'b0;
    model_clear();
    pat = GEN_PAT;

    // reset held with clock running and random data
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      x_tb = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("reset_hold_y", {31'd0, y}, 32'd0);
`ifdef SEQ_DET_COUNT_EN
      check("reset_hold_cnt", {24'd0, match_count}, 32'd0);
`endif
      check("reset_hold_seq", {31'd0, seq}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    // single match
    async_reset();
    for (int i = 0; i < 5; i++) step(bits_single[i], ys_single[i], "single");

    // overlapping matches, pulses 3 cycles apart
    async_reset();
    pulses = 0;
    last_pulse = -10;
    for (int i = 0; i < 7; i++) begin
      step(bits_ovl[i], ys_ovl[i], "overlap");
      if (y === 1'b1) begin
        if (pulses > 0) check("overlap_gap", i - last_pulse, 32'd3);
        pulses++;
        last_pulse = i;
      end
    end
    check("overlap_pulses", pulses, 32'd2);

    // near misses never match
    async_reset();
    for (int i = 0; i < 9; i++) step(bits_near[i], 0, "near");

    // reset in the middle of a pattern discards progress
    async_reset();
    step(1'b1, 0, "mid_pre");
    step(1'b0, 0, "mid_pre");
    step(1'b1, 0, "mid_pre");
    async_reset();
    step(1'b1, 0, "mid_post");
    step(1'b0, 0, "mid_post");
    step(1'b1, 0, "mid_post");
    step(1'b1, 1, "mid_post");

    // long random stream, biased towards 1 to produce many matches (counter wrap)
    async_reset();
    for (int i = 0; i < 4500; i++) begin
      step(1'($urandom_range(0, 99) < 60), -1, "random");
    end

    // detector fed by the generator for 64 cycles after reset
    async_reset();
    use_gen = 1'b1;
    pulses  = 0;
    for (int e = 1; e <= 64; e++) begin
      step(1'b0, -1, "gen");
      // after edge e the generator shows stream bit e-1
      exp_seq = pat[15 - ((e - 1) % 16)];
      check("gen_seq", {31'd0, seq}, {31'd0, exp_seq});
      if (y === 1'b1) begin
        pulses++;
        bitidx = (e - 2) % 16;  // detector sampled stream bit e-2 on this edge
        check("gen_pulse_idx",
              {31'd0, (bitidx == 3 || bitidx == 6 || bitidx == 9 || bitidx == 12)},
              32'd1);
      end
    end
    check("gen_pulses", pulses, 32'd16);
`ifdef SEQ_DET_COUNT_EN
    check("gen_count", {24'd0, match_count}, 32'd16);
`endif
    use_gen = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
